// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared register offsets, defaults and byte-lane helper for the GPIO peripheral
package gpio_pkg;

  // Word offsets within the IO page (mem_addr[4:2])
  localparam logic [2:0] GPIO_OUT    = 3'd0;
  localparam logic [2:0] GPIO_OE     = 3'd1;
  localparam logic [2:0] GPIO_IN     = 3'd2;
  localparam logic [2:0] GPIO_SET    = 3'd3;
  localparam logic [2:0] GPIO_CLR    = 3'd4;
  localparam logic [2:0] GPIO_TOG    = 3'd5;
  localparam logic [2:0] GPIO_RISE   = 3'd6;
  localparam logic [2:0] GPIO_IRQ_EN = 3'd7;

  // Address bit that splits the bus between RAM (0) and IO (1)
  localparam int GPIO_IO_ADDR_BIT = 22;

  // Expand the 4-bit byte write mask into a 32-bit bit mask
  function automatic logic [31:0] byte_mask_expand(input logic [3:0] wmask);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{wmask[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - two-flop pin synchroniser with rising-edge detection
module gpio_sync_edge #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o
);

  logic [W-1:0] sync1_q;
  logic [W-1:0] sync2_q;
  logic [W-1:0] prev_q;
  // Warm-up shift: edge detection stays off until sync2 and prev both hold
  // real pin samples, so a pin held high through reset never looks like a rise.
  logic [2:0]   warm_q;

  // Synchroniser chain, previous-sample register and warm-up tracker
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= {warm_q[1:0], 1'b1};
    end
  end

  assign sync_o = sync2_q;
  assign rise_o = sync2_q & ~prev_q & {W{warm_q[2]}};

endmodule

// File: rtl/gpio_mmio.sv
// rtl/gpio_mmio.sv - memory-mapped GPIO block with edge flags and level interrupt
module gpio_mmio
  import gpio_pkg::*;
#(
  parameter int NGPIO       = 8,
  parameter int IO_ADDR_BIT = GPIO_IO_ADDR_BIT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      mem_addr,
  output logic [31:0]      mem_rdata,
  input  logic             mem_rstrb,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wmask,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_oe,
  output logic             irq
);

  logic             sel;
  logic             wr_en;
  logic             rd_en;
  logic [2:0]       reg_off;
  logic [31:0]      lane_mask;
  logic [NGPIO-1:0] wmask_n;
  logic [NGPIO-1:0] wbits_n;
  logic [NGPIO-1:0] in_sync;
  logic [NGPIO-1:0] rise;
  logic [31:0]      rd_val;

  logic [NGPIO-1:0] out_q, out_d;
  logic [NGPIO-1:0] oe_q, oe_d;
  logic [NGPIO-1:0] en_q, en_d;
  logic [NGPIO-1:0] flags_q, flags_d;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;

  // Address bits outside the decode and data bits above NGPIO are don't-care
  logic unused_bits;
  assign unused_bits = ^{mem_addr, mem_wdata, lane_mask};

  assign sel       = mem_addr[IO_ADDR_BIT];
  assign reg_off   = mem_addr[4:2];
  assign wr_en     = sel && (mem_wmask != 4'b0000);
  assign rd_en     = sel && mem_rstrb;
  assign lane_mask = byte_mask_expand(mem_wmask);
  assign wmask_n   = lane_mask[NGPIO-1:0];
  // Masked-off lanes behave as zero data for SET/CLR/TOG/W1C
  assign wbits_n   = mem_wdata[NGPIO-1:0] & wmask_n;

  gpio_sync_edge #(.W(NGPIO)) u_sync_edge (
    .clk    (clk),
    .resetn (resetn),
    .pin_i  (gpio_in),
    .sync_o (in_sync),
    .rise_o (rise)
  );

  // Register write decode, rise-flag update and interrupt next state
  always_comb begin
    out_d   = out_q;
    oe_d    = oe_q;
    en_d    = en_q;
    flags_d = flags_q;
    if (wr_en) begin
      case (reg_off)
        GPIO_OUT:    out_d   = (out_q & ~wmask_n) | wbits_n;
        GPIO_OE:     oe_d    = (oe_q & ~wmask_n) | wbits_n;
        GPIO_SET:    out_d   = out_q | wbits_n;
        GPIO_CLR:    out_d   = out_q & ~wbits_n;
        GPIO_TOG:    out_d   = out_q ^ wbits_n;
        GPIO_RISE:   flags_d = flags_q & ~wbits_n;
        GPIO_IRQ_EN: en_d    = (en_q & ~wmask_n) | wbits_n;
        default:     ;
      endcase
    end
    // A new rise overrides a same-cycle clear
    flags_d = flags_d | rise;
    irq_d   = |(flags_q & en_q);
  end

  // Read mux sampling pre-write register values
  always_comb begin
    rd_val = '0;
    case (reg_off)
      GPIO_OUT:    rd_val[NGPIO-1:0] = out_q;
      GPIO_OE:     rd_val[NGPIO-1:0] = oe_q;
      GPIO_IN:     rd_val[NGPIO-1:0] = in_sync;
      GPIO_RISE:   rd_val[NGPIO-1:0] = flags_q;
      GPIO_IRQ_EN: rd_val[NGPIO-1:0] = en_q;
      default:     rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  // Architectural state with asynchronous clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q   <= '0;
      oe_q    <= '0;
      en_q    <= '0;
      flags_q <= '0;
      irq_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      en_q    <= en_d;
      flags_q <= flags_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign gpio_out  = out_q;
  assign gpio_oe   = oe_q;
  assign irq       = irq_q;
  assign mem_rdata = rdata_q;

endmodule
